seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Captures the segment pattern of a multiplexed 7-segment display and decodes it.
// Each digit is decoded once stable, and the assembled frame goes out through a valid/ready register.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err,
    output logic                    sync_err,
    output logic                    ovf
);
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] STABLE_U8 = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {SYNC, STAB, HELD} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              cnt_inc;
    logic [6:0]              seg_prev_q;
    logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
    logic [NUM_DIGITS-1:0]   ferr_q, ferr_d;
    logic [4*NUM_DIGITS-1:0] out_bcd_q, out_bcd_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_err_q, out_err_d;
    logic                    sync_err_q, sync_err_d;
    logic                    ovf_q, ovf_d;

    logic [NUM_DIGITS-1:0]   oh_k, oh_k1, oh_0;
    logic                    last_k;
    logic [6:0]              seg_p;
    logic [3:0]              dec_bcd;
    logic                    dec_err;
    logic                    cap, start, complete, load;
    logic [KW-1:0]           cap_idx, start_idx;

    // One-hot patterns for the current digit and its successor.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
            assign oh_k[gi]  = (k_q == KW'(gi));
            assign oh_k1[gi] = ((k_q + KW'(1)) == KW'(gi));
            assign oh_0[gi]  = (gi == 0);
        end
    endgenerate

    assign last_k  = (k_q == KW'(NUM_DIGITS - 1));
    assign cnt_inc = cnt_q + 8'd1;
    assign seg_p   = ~seg_n;

    always_comb begin
        dec_bcd = 4'hE;
        dec_err = 1'b1;
        case (seg_p)
            7'h3F: begin dec_bcd = 4'h0; dec_err = 1'b0; end
            7'h06: begin dec_bcd = 4'h1; dec_err = 1'b0; end
            7'h5B: begin dec_bcd = 4'h2; dec_err = 1'b0; end
            7'h4F: begin dec_bcd = 4'h3; dec_err = 1'b0; end
            7'h66: begin dec_bcd = 4'h4; dec_err = 1'b0; end
            7'h6D: begin dec_bcd = 4'h5; dec_err = 1'b0; end
            7'h7D: begin dec_bcd = 4'h6; dec_err = 1'b0; end
            7'h07: begin dec_bcd = 4'h7; dec_err = 1'b0; end
            7'h7F: begin dec_bcd = 4'h8; dec_err = 1'b0; end
            7'h6F: begin dec_bcd = 4'h9; dec_err = 1'b0; end
            7'h00: begin dec_bcd = 4'hF; dec_err = 1'b0; end
            default: begin end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        sync_err_d = 1'b0;
        cap        = 1'b0;
        cap_idx    = k_q;
        start      = 1'b0;
        start_idx  = '0;
        complete   = 1'b0;

        case (state_q)
            SYNC: begin
                if (dig_en == oh_0) begin
                    start = 1'b1;
                end
            end
            STAB: begin
                if (dig_en == oh_k) begin
                    if (seg_n != seg_prev_q) begin
                        cnt_d = 8'd1;
                    end else if (cnt_inc == STABLE_U8) begin
                        cnt_d   = cnt_inc;
                        cap     = 1'b1;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    sync_err_d = 1'b1;
                    state_d    = SYNC;
                    k_d        = '0;
                    cnt_d      = '0;
                end
            end
            HELD: begin
                if (dig_en != oh_k && dig_en != '0) begin
                    if (!last_k && dig_en == oh_k1) begin
                        start     = 1'b1;
                        start_idx = k_q + KW'(1);
                    end else if (dig_en == oh_0) begin
                        // Wrap to digit 0 closes the frame only after the last digit.
                        start      = 1'b1;
                        complete   = last_k;
                        sync_err_d = !last_k;
                    end else begin
                        sync_err_d = 1'b1;
                        state_d    = SYNC;
                        k_d        = '0;
                        cnt_d      = '0;
                    end
                end
            end
            default: begin
                state_d = SYNC;
                k_d     = '0;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            k_d   = start_idx;
            cnt_d = 8'd1;
            if (STABLE_CYCLES == 1) begin
                cap     = 1'b1;
                cap_idx = start_idx;
                state_d = HELD;
            end else begin
                state_d = STAB;
            end
        end
    end

    always_comb begin
        frame_d = frame_q;
        ferr_d  = ferr_q;
        if (cap) begin
            frame_d[4*cap_idx +: 4] = dec_bcd;
            ferr_d[cap_idx]         = dec_err;
        end
    end

    // Completed frame comes from frame_q, so a same-edge capture into slot 0 never leaks in.
    always_comb begin
        load        = complete && (!out_valid_q || out_ready);
        ovf_d       = complete && out_valid_q && !out_ready;
        out_bcd_d   = load ? frame_q : out_bcd_q;
        out_err_d   = load ? (|ferr_q) : out_err_q;
        out_valid_d = load || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            k_q         <= '0;
            cnt_q       <= '0;
            seg_prev_q  <= '0;
            frame_q     <= '0;
            ferr_q      <= '0;
            out_bcd_q   <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            seg_prev_q  <= seg_n;
            frame_q     <= frame_d;
            ferr_q      <= ferr_d;
            out_bcd_q   <= out_bcd_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            sync_err_q  <= sync_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_bcd   = out_bcd_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign sync_err  = sync_err_q;
    assign ovf       = ovf_q;

endmodule
